instr_flash_fetch: RTL and testbench

- Synchronous read initiator for the two S29AL008J-style parallel instruction flash devices. The lower device supplies bits 15:0 and the upper device supplies bits 31:16 of each instruction.
- Accepts word-aligned fetch byte addresses from the core and generates the flash reset, CE#, OE# and address timing.
- Samples both 16-bit data buses and returns a 32-bit instruction over a valid/ready response channel.
- Sits between the fetch stage and the board-level flash pins.

---
 rtl/instr_flash_fetch.sv | 179 +++++++++++++++++
 tb/tb_instr_flash_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_flash_fetch.sv
// Read initiator for two 16-bit parallel instruction flashes forming one 32-bit word.
// Drives registered CE#/OE#/RESET#/A and returns the sampled word over a valid/ready channel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RST_LO  | flash_reset_n held low after core reset
// RST_REC | flash_reset_n high, waiting for device recovery
// IDLE    | ready to accept a fetch request
// ACCESS  | CE#/OE# low, waiting for data to settle
// RESP    | response presented, waiting for rsp_ready (or flush)
// TURN    | CE#/OE# high for bus release between accesses
module instr_flash_fetch #(
    parameter int unsigned ACCESS_CYCLES  = 7,
    parameter int unsigned TURN_CYCLES    = 2,
    parameter int unsigned RST_LO_CYCLES  = 4,
    parameter int unsigned RST_REC_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        flush,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        flash_reset_n,
    output logic        flash_byte_n,
    output logic [18:0] flash_a,
    input  logic [15:0] flash_dq_lo,
    input  logic [15:0] flash_dq_hi
);

    typedef enum logic [2:0] {
        RST_LO,
        RST_REC,
        IDLE,
        ACCESS,
        RESP,
        TURN
    } state_t;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LO_LAST   = CNT_W'(RST_LO_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RST_REC_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 32'd0);

    state_t            state, state_nxt;
    state_t            after_rsp;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ce_nxt, oe_nxt, rstn_nxt;
    logic [18:0]       a_nxt;
    logic              valid_nxt, err_nxt;
    logic [31:0]       data_nxt;
    logic              addr_bad;

    assign flash_we_n   = 1'b1;
    assign flash_byte_n = 1'b1;
    assign req_ready    = (state == IDLE) && !flush;
    assign addr_bad     = (req_addr[1:0] != 2'b00) || (req_addr[31:20] != 12'h000);
    // With no turnaround configured the bus goes straight back to IDLE.
    assign after_rsp    = (TURN_CYCLES == 0) ? IDLE : TURN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RST_LO;
            cnt           <= '0;
            flash_ce_n    <= 1'b1;
            flash_oe_n    <= 1'b1;
            flash_reset_n <= 1'b0;
            flash_a       <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            flash_ce_n    <= ce_nxt;
            flash_oe_n    <= oe_nxt;
            flash_reset_n <= rstn_nxt;
            flash_a       <= a_nxt;
            rsp_valid     <= valid_nxt;
            rsp_data      <= data_nxt;
            rsp_err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ce_nxt    = flash_ce_n;
        oe_nxt    = flash_oe_n;
        rstn_nxt  = flash_reset_n;
        a_nxt     = flash_a;
        valid_nxt = rsp_valid;
        data_nxt  = rsp_data;
        err_nxt   = rsp_err;
        case (state)
            RST_LO: begin
                rstn_nxt = 1'b0;
                if (cnt == LO_LAST) begin
                    cnt_nxt   = '0;
                    rstn_nxt  = 1'b1;
                    state_nxt = RST_REC;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RST_REC: begin
                if (cnt == REC_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (req_valid && req_ready) begin
                    cnt_nxt = '0;
                    if (addr_bad) begin
                        valid_nxt = 1'b1;
                        err_nxt   = 1'b1;
                        data_nxt  = '0;
                        state_nxt = RESP;
                    end else begin
                        a_nxt     = {req_addr[19:2], 1'b0};
                        ce_nxt    = 1'b0;
                        oe_nxt    = 1'b0;
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (flush) begin
                    ce_nxt    = 1'b1;
                    oe_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = after_rsp;
                end else if (cnt == ACC_LAST) begin
                    data_nxt  = {flash_dq_hi, flash_dq_lo};
                    err_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    ce_nxt    = 1'b1;
                    oe_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                // flush and a normal handshake leave RESP identically
                if (flush || rsp_ready) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = after_rsp;
                end
            end
            TURN: begin
                if (cnt == TURN_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RST_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_flash_fetch.sv
// Scoreboard bench for instr_flash_fetch: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_instr_flash_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        flush;
    logic        flash_ce_n, flash_oe_n, flash_we_n, flash_reset_n, flash_byte_n;
    logic [18:0] flash_a;
    logic [15:0] flash_dq_lo, flash_dq_hi;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          pass_cnt  = 0;
    int          check_cnt = 0;
    int unsigned cyc       = 0;
    bit          ce_low_seen = 1'b0;

    instr_flash_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .flush         (flush),
        .flash_ce_n    (flash_ce_n),
        .flash_oe_n    (flash_oe_n),
        .flash_we_n    (flash_we_n),
        .flash_reset_n (flash_reset_n),
        .flash_byte_n  (flash_byte_n),
        .flash_a       (flash_a),
        .flash_dq_lo   (flash_dq_lo),
        .flash_dq_hi   (flash_dq_hi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!flash_ce_n) ce_low_seen = 1'b1;

    // Flash pair model: drives data only while both CE# and OE# are low.
    always_comb begin
        flash_dq_lo = 16'hFFFF;
        flash_dq_hi = 16'hFFFF;
        if (!flash_ce_n && !flash_oe_n) begin
            case (flash_a)
                19'h00000: begin flash_dq_lo = 16'h1111; flash_dq_hi = 16'h2222; end
                19'h00002: begin flash_dq_lo = 16'h3333; flash_dq_hi = 16'h4444; end
                19'h00004: begin flash_dq_lo = 16'h0093; flash_dq_hi = 16'h00A0; end
                default:   begin flash_dq_lo = 16'hDEAD; flash_dq_hi = 16'hBEEF; end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every response handshake must match the head of the scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Call from posedge+1; returns at accept edge + 1 with acc_cyc = edge count.
    task automatic do_req(input logic [31:0] addr, input bit expect_rsp,
                          input logic [31:0] d, input logic e, output int unsigned acc_cyc);
        bit seen;
        int n = 0;
        req_addr  = addr;
        req_valid = 1'b1;
        forever begin
            @(negedge clk);
            seen = req_ready;
            @(posedge clk);
            if (seen || n > 200) break;
            n++;
        end
        if (n > 200) chk("accept_timeout", 32'(n), 32'd0);
        if (expect_rsp) exp_q.push_back('{data: d, err: e});
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) chk("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks, expected completion", check_cnt);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t, t0, t1, t2, fl_cyc;
        int n, a_bad;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ce_n",    32'(flash_ce_n), 32'd1);
        chk("rst_oe_n",    32'(flash_oe_n), 32'd1);
        chk("rst_reset_n", 32'(flash_reset_n), 32'd0);
        chk("rst_a",       32'(flash_a), 32'd0);
        chk("rst_ready",   32'(req_ready), 32'd0);
        chk("rst_valid",   32'(rsp_valid), 32'd0);
        chk("rst_data",    rsp_data, 32'd0);
        chk("rst_err",     32'(rsp_err), 32'd0);
        chk("we_n",        32'(flash_we_n), 32'd1);
        chk("byte_n",      32'(flash_byte_n), 32'd1);

        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("seq_reset_n_%0d", k), 32'(flash_reset_n), 32'(k >= 4));
            chk($sformatf("seq_ready_%0d", k),   32'(req_ready),     32'(k >= 7));
            chk($sformatf("seq_ce_n_%0d", k),    32'(flash_ce_n),    32'd1);
        end

        flush = 1'b1; #1;
        chk("idle_flush_ready", 32'(req_ready), 32'd0);
        flush = 1'b0; #1;
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Single read of 0x8
        @(posedge clk); #1;
        do_req(32'h0000_0008, 1'b1, 32'h00A0_0093, 1'b0, t);
        n = 0; a_bad = 0;
        forever begin
            @(negedge clk);
            if (flash_ce_n || n > 50) break;
            n++;
            if (flash_a != 19'h00004 || flash_oe_n) a_bad++;
        end
        chk("ce_low_cycles", 32'(n), 32'd7);
        chk("a_oe_during_access", 32'(a_bad), 32'd0);
        chk("valid_after_access", 32'(rsp_valid), 32'd1);

        // Backpressure on a read of 0x4
        wait_ready();
        rsp_ready = 1'b0;
        do_req(32'h0000_0004, 1'b1, 32'h4444_3333, 1'b0, t);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",   32'(rsp_valid), 32'd1);
            chk("bp_data",    rsp_data, 32'h4444_3333);
            chk("bp_ready",   32'(req_ready), 32'd0);
            chk("bp_ce_n",    32'(flash_ce_n), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", 32'(rsp_valid), 32'd0);

        // Misaligned and out-of-range requests
        wait_ready();
        ce_low_seen = 1'b0;
        do_req(32'h0000_0006, 1'b1, 32'h0, 1'b1, t);
        @(negedge clk);
        chk("misalign_latency", 32'(rsp_valid), 32'd1);
        wait_ready();
        do_req(32'h0010_0000, 1'b1, 32'h0, 1'b1, t);
        @(negedge clk);
        chk("range_latency", 32'(rsp_valid), 32'd1);
        wait_ready();
        chk("ce_during_err", 32'(ce_low_seen), 32'd0);

        // Flush in the third ACCESS cycle
        do_req(32'h0000_0000, 1'b0, 32'h0, 1'b0, t);
        @(posedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush  = 1'b0;
        fl_cyc = cyc;
        chk("flush_ce_n",  32'(flash_ce_n), 32'd1);
        chk("flush_oe_n",  32'(flash_oe_n), 32'd1);
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        do_req(32'h0000_0008, 1'b1, 32'h00A0_0093, 1'b0, t);
        chk("flush_turn_gap", t - fl_cyc, 32'd3);
        wait_ready();

        // Back-to-back with rsp_ready held high
        do_req(32'h0000_0000, 1'b1, 32'h2222_1111, 1'b0, t0);
        do_req(32'h0000_0004, 1'b1, 32'h4444_3333, 1'b0, t1);
        do_req(32'h0000_0008, 1'b1, 32'h00A0_0093, 1'b0, t2);
        chk("b2b_gap1", t1 - t0, 32'd11);
        chk("b2b_gap2", t2 - t0, 32'd22);
        wait_ready();

        // Reset in the middle of an access
        do_req(32'h0000_0004, 1'b0, 32'h0, 1'b0, t);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ce_n",    32'(flash_ce_n), 32'd1);
        chk("midrst_oe_n",    32'(flash_oe_n), 32'd1);
        chk("midrst_reset_n", 32'(flash_reset_n), 32'd0);
        chk("midrst_valid",   32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        chk("midrst_ready_delay", 32'(n), 32'd7);
        @(posedge clk); #1;
        do_req(32'h0000_0000, 1'b1, 32'h2222_1111, 1'b0, t);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
